// File: rtl/m_cache_assoc_pkg.sv
// m_cache_assoc_pkg: shared state encodings, geometry constants and helpers for the associative cache
package m_cache_assoc_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int OFFSET_W   = 4;
    localparam logic [1:0] S_FLUSH  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_LOOKUP = 2'd2;
    localparam logic [1:0] S_REFILL = 2'd3;
    function automatic logic [3:0] word_be(input logic [1:0] w);
        return 4'b0001 << w;
    endfunction
endpackage

// File: rtl/m_cache_way.sv
// m_cache_way: one cache way with tag/valid/word RAMs, synchronous read, line install and flush clear
module m_cache_way #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 20
) (
    input  logic                   i_clk,
    input  logic                   i_rd_en,
    input  logic [INDEX_WIDTH-1:0] i_rd_idx,
    input  logic [INDEX_WIDTH-1:0] i_wr_idx,
    input  logic [3:0]             i_wr_be,
    input  logic [127:0]           i_wr_line,
    input  logic                   i_install,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    input  logic                   i_clr,
    input  logic [INDEX_WIDTH-1:0] i_clr_idx,
    output logic                   o_valid,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic [127:0]           o_data
);
    localparam int SETS = 2**INDEX_WIDTH;
    logic [SETS-1:0]      r_valid;
    logic [TAG_WIDTH-1:0] r_tag [SETS];
    logic                 r_valid_q;
    logic [TAG_WIDTH-1:0] r_tag_q;
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_valid_q <= r_valid[i_rd_idx];
            r_tag_q   <= r_tag[i_rd_idx];
        end
        if (i_install) r_tag[i_wr_idx] <= i_tag;
        if (i_clr) r_valid[i_clr_idx] <= 1'b0;
        else if (i_install) r_valid[i_wr_idx] <= 1'b1;
    end
    assign o_valid = r_valid_q;
    assign o_tag   = r_tag_q;
    for (genvar w = 0; w < 4; w++) begin : g_word
        logic [31:0] r_mem [SETS];
        logic [31:0] r_q;
        always_ff @(posedge i_clk) begin
            if (i_rd_en) r_q <= r_mem[i_rd_idx];
            if (i_wr_be[w]) r_mem[i_wr_idx] <= i_wr_line[32*w +: 32];
        end
        assign o_data[32*w +: 32] = r_q;
    end
endmodule

// File: rtl/m_cache_assoc.sv
// m_cache_assoc: N-way set-associative write-no-allocate data cache with line refill and flush sweep
module m_cache_assoc
    import m_cache_assoc_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int WAYS        = 2,
    parameter int ADDR_WIDTH  = ADDR_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_ready,
    output logic                  o_rvalid,
    output logic [31:0]           o_rdata,
    output logic                  o_mreq,
    output logic [ADDR_WIDTH-1:0] o_maddr,
    input  logic                  i_mvalid,
    input  logic [127:0]          i_mdata
);
    localparam int SETS      = 2**INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_W;
    localparam int PTR_W     = WAYS > 1 ? $clog2(WAYS) : 1;
    logic [1:0]             r_state;
    logic [INDEX_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0]  r_addr, r_maddr;
    logic                   r_we;
    logic [31:0]            r_wdata, r_rdata;
    logic [PTR_W-1:0]       r_ptr [SETS];
    logic [WAYS-1:0]        w_valid, w_hit_vec;
    logic [TAG_WIDTH-1:0]   w_tag_q [WAYS];
    logic [127:0]           w_data_q [WAYS];
    logic [127:0]           w_hit_line;
    logic [PTR_W-1:0]       w_victim;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic [1:0]             w_word;
    logic [31:0]            w_rword;
    logic w_accept, w_hit, w_store_hit, w_install, w_rvalid, w_unused;
    assign w_idx       = r_addr[INDEX_WIDTH+OFFSET_W-1:OFFSET_W];
    assign w_tag       = r_addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_W];
    assign w_word      = r_addr[3:2];
    assign w_unused    = ^r_addr[1:0];
    assign w_accept    = r_state == S_IDLE && i_req && !i_flush;
    assign w_hit       = |w_hit_vec;
    assign w_store_hit = r_state == S_LOOKUP && r_we && w_hit;
    // a refill arriving in the reset cycle must not leave a valid line behind
    assign w_install   = r_state == S_REFILL && i_mvalid && i_rst_n;
    assign w_rvalid    = (r_state == S_LOOKUP && !r_we && w_hit) || w_install;
    assign w_rword     = w_install ? i_mdata[{w_word, 5'b0} +: 32] : w_hit_line[{w_word, 5'b0} +: 32];
    assign o_ready     = r_state == S_IDLE;
    assign o_mreq      = r_state == S_REFILL;
    assign o_rvalid    = w_rvalid;
    assign o_rdata     = w_rvalid ? w_rword : r_rdata;
    assign o_maddr     = r_maddr;
    always_comb begin
        w_hit_line = '0;
        w_victim   = r_ptr[w_idx];
        for (int w = 0; w < WAYS; w++) w_hit_line |= w_hit_vec[w] ? w_data_q[w] : 128'b0;
        for (int w = WAYS - 1; w >= 0; w--) if (!w_valid[w]) w_victim = PTR_W'(w);
    end
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic       w_sel;
        logic [3:0] w_be;
        assign w_hit_vec[g] = w_valid[g] && w_tag_q[g] == w_tag;
        assign w_sel = w_install && w_victim == PTR_W'(g);
        assign w_be  = (w_store_hit && w_hit_vec[g]) ? word_be(w_word) : w_sel ? 4'hF : 4'h0;
        m_cache_way #(.INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_way (
            .i_clk     (i_clk),
            .i_rd_en   (w_accept),
            .i_rd_idx  (i_addr[INDEX_WIDTH+OFFSET_W-1:OFFSET_W]),
            .i_wr_idx  (w_idx),
            .i_wr_be   (w_be),
            .i_wr_line (w_install ? i_mdata : {4{r_wdata}}),
            .i_install (w_sel),
            .i_tag     (w_tag),
            .i_clr     (r_state == S_FLUSH),
            .i_clr_idx (r_cnt),
            .o_valid   (w_valid[g]),
            .o_tag     (w_tag_q[g]),
            .o_data    (w_data_q[g])
        );
    end
    always_ff @(posedge i_clk)
        if (r_state == S_FLUSH) r_ptr[r_cnt] <= '0;
        else if (w_install) r_ptr[w_idx] <= (r_ptr[w_idx] == PTR_W'(WAYS - 1)) ? '0 : r_ptr[w_idx] + 1'b1;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_maddr <= '0;
        end else begin
            if (w_rvalid) r_rdata <= w_rword;
            case (r_state)
                S_FLUSH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (i_flush) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= '0;
                    end else if (i_req) begin
                        r_state <= S_LOOKUP;
                        r_addr  <= i_addr;
                        r_we    <= i_we;
                        r_wdata <= i_wdata;
                    end
                end
                S_LOOKUP: begin
                    r_state <= (!r_we && !w_hit) ? S_REFILL : S_IDLE;
                    if (!r_we && !w_hit) r_maddr <= {r_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                end
                default: if (i_mvalid) r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_cache_assoc.sv
// tb_m_cache_assoc: directed scoreboard bench for the set-associative cache (16 sets, 2 ways)
module tb_m_cache_assoc;
    logic clk = 0, rst_n = 0, flush = 0, req = 0, we = 0, mvalid = 0;
    logic [31:0]  addr = 0, wdata = 0;
    logic [127:0] mdata = 0;
    logic ready, rvalid, mreq;
    logic [31:0] rdata, maddr, exp_d;
    int total = 0, bad = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    m_cache_assoc #(.INDEX_WIDTH(4), .WAYS(2), .ADDR_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_req(req), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_rvalid(rvalid),
        .o_rdata(rdata), .o_mreq(mreq), .o_maddr(maddr), .i_mvalid(mvalid), .i_mdata(mdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] b);
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction

    // monitor: every load response is matched against the oldest expected value
    always @(negedge clk) if (rvalid) begin
        if (q.size() == 0) check("unexpected_rvalid", {31'b0, rvalid}, 32'd0);
        else begin
            exp_d = q.pop_front();
            check("rdata", rdata, exp_d);
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'b0, ready}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        wait_ready();
        req = 1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 0;
    endtask

    task automatic count_flush(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ready && n < 100);
        check(name, n, 32'd16);
    endtask

    task automatic load(input logic [31:0] a, input logic miss, input logic [127:0] line, input logic [31:0] exp);
        issue(a, 1'b0, 32'd0);
        if (!miss) q.push_back(exp);
        @(negedge clk);
        check("lookup_hit", {31'b0, rvalid}, {31'b0, !miss});
        @(negedge clk);
        check("mreq", {31'b0, mreq}, {31'b0, miss});
        if (miss) begin
            check("maddr", maddr, a & 32'hFFFF_FFF0);
            repeat (3) @(negedge clk);
            check("mreq_held", {31'b0, mreq}, 32'd1);
            @(posedge clk);
            #1 q.push_back(exp);
            mvalid = 1; mdata = line;
            @(posedge clk);
            #1 mvalid = 0;
            @(negedge clk);
            check("ready_after_refill", {31'b0, ready}, 32'd1);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        issue(a, 1'b1, d);
        @(negedge clk);
        check("store_no_rvalid", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        check("store_no_mreq", {31'b0, mreq}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_mreq", {31'b0, mreq}, 32'd0);
        check("rst_maddr", maddr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1;
        count_flush("reset_flush_cycles");
        load(32'h104, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA}, 32'hB);
        load(32'h10C, 1'b0, '0, 32'hD);
        check("rdata_hold", rdata, 32'hD);
        store(32'h108, 32'h55);
        load(32'h108, 1'b0, '0, 32'h55);
        load(32'h100, 1'b0, '0, 32'hA);
        store(32'h2008, 32'h77);
        load(32'h2008, 1'b1, mk(32'h2000), 32'h2008);
        load(32'h2008, 1'b0, '0, 32'h2008);
        wait_ready();
        flush = 1; req = 1; we = 0; addr = 32'h104;
        @(posedge clk);
        #1 flush = 0; req = 0;
        @(negedge clk);
        check("flush_not_ready", {31'b0, ready}, 32'd0);
        check("flush_no_rvalid", {31'b0, rvalid}, 32'd0);
        count_flush("cmd_flush_cycles");
        load(32'h000, 1'b1, mk(32'h000), 32'h000);
        load(32'h100, 1'b1, mk(32'h100), 32'h100);
        load(32'h200, 1'b1, mk(32'h200), 32'h200);
        load(32'h104, 1'b0, '0, 32'h104);
        load(32'h30C, 1'b1, mk(32'h300), 32'h30C);
        load(32'h004, 1'b1, mk(32'h000), 32'h004);
        load(32'h308, 1'b0, '0, 32'h308);
        load(32'h108, 1'b1, mk(32'h100), 32'h108);
        load(32'h204, 1'b1, mk(32'h200), 32'h204);
        load(32'h10C, 1'b0, '0, 32'h10C);
        issue(32'h500, 1'b0, 32'd0);
        @(negedge clk); @(negedge clk);
        check("rr_mreq", {31'b0, mreq}, 32'd1);
        rst_n = 0;
        @(posedge clk); @(negedge clk);
        check("rr_mreq_drop", {31'b0, mreq}, 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1 mvalid = 1; mdata = mk(32'h500);
        @(negedge clk);
        check("late_mvalid_no_rvalid", {31'b0, rvalid}, 32'd0);
        @(posedge clk);
        #1 mvalid = 0;
        load(32'h504, 1'b1, mk(32'h500), 32'h504);
        load(32'h10C, 1'b1, mk(32'h100), 32'h10C);
        load(32'h500, 1'b0, '0, 32'h500);
        check("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
